// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NCO voices with retrigger/free/LRU-steal priority.
// Note-on: ROM_LAT+2 edges from accept to voice outputs; note-off: 1 edge. ev_ready low while an event is in flight.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int FREQ_W     = 24,
    parameter int ROM_LAT    = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic                         all_off,
    output logic [NOTE_W-1:0]            rom_addr,
    input  logic [FREQ_W-1:0]            rom_data,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic                         busy
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOOKUP, S_WRITE} state_t;

    state_t                               state_q, state_d;
    logic                                 on_q, on_d;
    logic [NOTE_W-1:0]                    note_q, note_d;
    logic [IW-1:0]                        tgt_q, tgt_d;
    logic [LW-1:0]                        cnt_q, cnt_d;
    logic [NOTE_W-1:0]                    rom_addr_q, rom_addr_d;
    logic [NUM_VOICES-1:0][FREQ_W-1:0]    freq_q, freq_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]    vnote_q, vnote_d;
    logic [NUM_VOICES-1:0][IW-1:0]        rank_q, rank_d;
    logic [NUM_VOICES-1:0]                gate_q, gate_d;
    logic [NUM_VOICES-1:0]                load_q, load_d;

    logic          hit_vld, free_vld;
    logic [IW-1:0] hit_idx, free_idx, old_idx, tsel;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_vld  = 1'b0;
        hit_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (vnote_q[i] == note_q)) begin
                hit_vld = 1'b1;
                hit_idx = IW'(i);
            end
            if (!gate_q[i]) begin
                free_vld = 1'b1;
                free_idx = IW'(i);
            end
            if (rank_q[i] == IW'(NUM_VOICES - 1)) begin
                old_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        on_d       = on_q;
        note_d     = note_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        freq_d     = freq_q;
        vnote_d    = vnote_q;
        rank_d     = rank_q;
        gate_d     = gate_q;
        load_d     = '0;
        tsel       = hit_vld ? hit_idx : (free_vld ? free_idx : old_idx);
        ev_ready   = (state_q == S_IDLE) && !all_off;

        case (state_q)
            S_IDLE: begin
                if (ev_valid && ev_ready) begin
                    on_d    = ev_on;
                    note_d  = ev_note;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!on_q) begin
                    if (hit_vld) gate_d[hit_idx] = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tgt_d      = tsel;
                    rom_addr_d = note_q;
                    cnt_d      = '0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IW'(i) == tsel) begin
                            rank_d[i] = '0;
                        end else if (rank_q[i] < rank_q[tsel]) begin
                            rank_d[i] = rank_q[i] + 1'b1;
                        end
                    end
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cnt_q == LW'(ROM_LAT - 1)) state_d = S_WRITE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            S_WRITE: begin
                freq_d[tgt_q]  = rom_data;
                vnote_d[tgt_q] = note_q;
                gate_d[tgt_q]  = 1'b1;
                load_d[tgt_q]  = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Panic release: abort whatever is in flight but keep LRU history and frequencies.
        if (all_off) begin
            gate_d  = '0;
            load_d  = '0;
            freq_d  = freq_q;
            vnote_d = vnote_q;
            rank_d  = rank_q;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            on_q       <= 1'b0;
            note_q     <= '0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            freq_q     <= '0;
            vnote_q    <= '0;
            gate_q     <= '0;
            load_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= IW'(i);
        end else begin
            state_q    <= state_d;
            on_q       <= on_d;
            note_q     <= note_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            freq_q     <= freq_d;
            vnote_q    <= vnote_d;
            gate_q     <= gate_d;
            load_q     <= load_d;
            rank_q     <= rank_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign voice_freq = freq_q;
    assign voice_gate = gate_q;
    assign voice_load = load_q;
    assign busy       = ~ev_ready;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a registered note ROM model (ROM_LAT = 1).
module tb_voice_allocator;

    logic        Clk = 1'b0;
    logic        Reset, ev_valid, ev_ready, ev_on, all_off, busy;
    logic [6:0]  ev_note, rom_addr;
    logic [23:0] rom_data;
    logic [95:0] voice_freq;
    logic [3:0]  voice_gate, voice_load;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    voice_allocator #(.NUM_VOICES(4), .NOTE_W(7), .FREQ_W(24), .ROM_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .all_off(all_off), .rom_addr(rom_addr), .rom_data(rom_data),
        .voice_freq(voice_freq), .voice_gate(voice_gate), .voice_load(voice_load), .busy(busy)
    );

    function automatic logic [23:0] rom_val(input logic [6:0] n);
        return (n == 7'h45) ? 24'h0258BF : {1'b0, n, 8'h3C, 1'b1, n};
    endfunction

    always @(posedge Clk) rom_data <= rom_val(rom_addr);

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic note_on(input logic [6:0] n, input int v, input logic [3:0] gate_exp);
        check("on_ready", 96'(ev_ready), 96'(1));
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = n;
        tick();
        ev_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("on_busy", 96'(ev_ready), 96'(0));
            check("on_noload", 96'(voice_load), 96'(0));
            if (c < 2) tick();
        end
        tick();
        check("on_load", 96'(voice_load), 96'(4'b0001 << v));
        check("on_freq", 96'(voice_freq[v*24 +: 24]), 96'(rom_val(n)));
        check("on_gate", 96'(voice_gate), 96'(gate_exp));
        check("on_ready_back", 96'(ev_ready), 96'(1));
        tick();
        check("on_load_pulse", 96'(voice_load), 96'(0));
    endtask

    task automatic note_off(input logic [6:0] n, input logic [3:0] gate_exp);
        check("off_ready", 96'(ev_ready), 96'(1));
        ev_valid = 1'b1; ev_on = 1'b0; ev_note = n;
        tick();
        ev_valid = 1'b0;
        check("off_busy", 96'(ev_ready), 96'(0));
        tick();
        check("off_ready_back", 96'(ev_ready), 96'(1));
        check("off_noload1", 96'(voice_load), 96'(0));
        tick();
        check("off_gate", 96'(voice_gate), 96'(gate_exp));
        check("off_noload2", 96'(voice_load), 96'(0));
    endtask

    initial begin
        Reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; all_off = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_freq", voice_freq, 96'(0));
        check("rst_gate", 96'(voice_gate), 96'(0));
        check("rst_load", 96'(voice_load), 96'(0));
        check("rst_addr", 96'(rom_addr), 96'(0));
        check("rst_ready", 96'(ev_ready), 96'(1));
        check("rst_busy", 96'(busy), 96'(0));

        // First note lands on voice 0 with the known ROM word.
        note_on(7'h45, 0, 4'b0001);
        check("t1_freq", 96'(voice_freq[23:0]), 96'(24'h0258BF));

        // Fill all voices, then steal the two oldest in turn.
        do_reset();
        note_on(7'h40, 0, 4'b0001);
        note_on(7'h41, 1, 4'b0011);
        note_on(7'h42, 2, 4'b0111);
        note_on(7'h43, 3, 4'b1111);
        note_on(7'h44, 0, 4'b1111);
        note_on(7'h45, 1, 4'b1111);
        check("steal_all_freq", voice_freq,
              {rom_val(7'h43), rom_val(7'h42), 24'h0258BF, rom_val(7'h44)});

        // Release a matched note, then an unmatched one.
        note_off(7'h42, 4'b1011);
        note_off(7'h7F, 4'b1011);
        check("off_freq_kept", voice_freq,
              {rom_val(7'h43), rom_val(7'h42), 24'h0258BF, rom_val(7'h44)});

        // Same note twice retriggers the same voice.
        do_reset();
        note_on(7'h30, 0, 4'b0001);
        note_on(7'h30, 0, 4'b0001);
        check("retrig_v1_gate", 96'(voice_gate[1]), 96'(0));

        // Panic has priority over an accept in IDLE.
        do_reset();
        all_off = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'h50;
        #1;
        check("panic_ready", 96'(ev_ready), 96'(0));
        check("panic_busy", 96'(busy), 96'(1));
        tick();
        all_off = 1'b0; ev_valid = 1'b0;
        #1;
        check("panic_not_accepted", 96'(ev_ready), 96'(1));

        // Panic during LOOKUP aborts the in-flight note.
        note_on(7'h40, 0, 4'b0001);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'h41;
        tick();
        ev_valid = 1'b0;
        tick();
        all_off = 1'b1;
        #1;
        check("abort_ready_low", 96'(ev_ready), 96'(0));
        tick();
        all_off = 1'b0;
        check("abort_gate", 96'(voice_gate), 96'(0));
        check("abort_noload", 96'(voice_load), 96'(0));
        #1;
        check("abort_idle", 96'(ev_ready), 96'(1));
        tick();
        check("abort_noload2", 96'(voice_load), 96'(0));
        check("abort_v1_freq", 96'(voice_freq[47:24]), 96'(0));
        note_on(7'h42, 0, 4'b0001);

        // Reset in WRITE with a pending event: nothing is applied.
        do_reset();
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'h40;
        tick();
        ev_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'h55;
        tick();
        Reset = 1'b0; ev_valid = 1'b0;
        check("wrst_freq", voice_freq, 96'(0));
        check("wrst_gate", 96'(voice_gate), 96'(0));
        check("wrst_load", 96'(voice_load), 96'(0));
        check("wrst_addr", 96'(rom_addr), 96'(0));
        check("wrst_ready", 96'(ev_ready), 96'(1));
        tick();
        check("wrst_load2", 96'(voice_load), 96'(0));
        check("wrst_gate2", 96'(voice_gate), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
